gelu_requant_q35: RTL and testbench
===================================

Name: gelu_requant_q35

Overview:
- Upstream feeder for the piecewise GELU stage.
- Takes signed accumulator values from the MAC array and rescales them with a per-tensor integer multiplier and right shift.
- Rounds, then saturates to the signed 8-bit Q3.5 code range (-128..127, i.e. -4.0..+3.96875) that the GELU stage expects.
- Two-stage valid/ready pipeline with full backpressure, plus a saturation-event counter for calibration.

Parameters:
- ACC_W, 24, accumulator input width (signed).
- MULT_W, 16, requant multiplier width (unsigned).
- SHIFT_W, 5, right-shift amount width (0..31).
- CNT_W, 16, saturation counter width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- cfg_mult  input  MULT_W  unsigned scale; quasi-static, sampled when a beat enters stage 1.
- cfg_shift  input  SHIFT_W  right-shift amount; sampled with cfg_mult.
- in_valid  input  1  acc_in is valid.
- in_ready  output  1  block accepts a beat this cycle.
- acc_in  input  ACC_W  signed accumulator value.
- out_valid  output  1  y_q35 is valid.
- out_ready  input  1  downstream (GELU) accepts.
- y_q35  output  8  signed Q3.5 result.
- sat_flag  output  1  this output beat was clamped; qualified by out_valid.
- sat_count  output  CNT_W  number of clamped beats delivered; saturates at all-ones.
- sat_clr  input  1  synchronous clear of sat_count.

Behaviour:
- **Reset** (synchronous, active-high): s1_valid = 0, s2_valid = 0, out_valid = 0, y_q35 = 0, sat_flag = 0, sat_count = 0.
  - in_ready reads 1 in the first cycle after reset deasserts.
  - Beats in flight when reset is asserted are discarded; no partial output appears.
- **Handshake** (transfer occurs when valid && ready on the same edge):
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is a combinational path from out_ready and is permitted.
  - out_valid = s2_valid; y_q35 and sat_flag come from registered stage 2.
  - out_valid, once asserted, stays high and y_q35/sat_flag stay stable until out_ready.
- **Stage 1** (on in_valid && in_ready):
  - prod = acc_in * {0, cfg_mult}, signed, width ACC_W+MULT_W+1.
  - Register prod together with cfg_shift.
- **Stage 2** (when s1_valid && s2_adv):
  - If shift == 0, r = prod.
  - Otherwise, r = (prod + 2^(shift-1)) >>> shift. This is round-half-up, toward +inf on ties.
  - The rounding addition uses one extra guard bit so it cannot overflow.
  - If r > 127: y = 127 and sat_flag = 1.
  - If r < -128: y = -128 and sat_flag = 1.
  - Otherwise: y = r[7:0] and sat_flag = 0.
- **Latency and throughput**:
  - Latency is 2 cycles from input handshake to out_valid when out_ready is held high.
  - Throughput is 1 beat per clock.
  - Order is preserved; no beat is dropped or duplicated.
- **Backpressure**:
  - With out_ready held low, at most 2 beats are buffered.
  - in_ready falls in the cycle after the second beat is accepted.
- **Simultaneous events**:
  - When out_ready is asserted on a full pipe, stage 2 drains, stage 1 moves up, and a new input is accepted, all on the same edge.
- **sat_count**:
  - Increments on each output handshake with sat_flag = 1.
  - Holds at 2^CNT_W - 1.
  - sat_clr has priority over an increment on the same edge; the result is 0.
- **Config changes**:
  - Each beat uses the cfg values present at its own stage-1 capture.
  - Changing cfg mid-stream affects only later beats.

Test Plan:
- **Nominal scaling**: acc_in = 100, cfg_mult = 32768, cfg_shift = 16, out_ready = 1 -> y_q35 = 50 exactly 2 cycles after the handshake, sat_flag = 0.
- **Rounding ties**: mult = 1, shift = 1.
  - acc = 3 -> 2; acc = -3 -> -1; acc = 5 -> 3.
  - shift = 0 with acc = -7 -> -7.
- **Saturation**: mult = 1, shift = 0.
  - acc = -100000 -> -128, sat_flag = 1.
  - acc = 200 -> 127, sat_flag = 1.
  - acc = 127 -> 127, sat_flag = 0.
  - sat_count = 2 after these beats are delivered; sat_clr pulsed -> 0.
- **Backpressure**: offer 4 beats (acc = 1, 2, 3, 4; mult = 1, shift = 0) with out_ready = 0 for 5 cycles.
  - Exactly 2 are accepted and in_ready = 0.
  - Raise out_ready -> outputs 1, 2, 3, 4 in order, with out_valid and y_q35 stable while stalled.
- **Reset mid-stream**: with 2 beats buffered, assert reset for 1 cycle.
  - out_valid = 0 and sat_count = 0 on the next cycle.
  - The buffered beats never appear.
  - A new beat after reset emerges with 2-cycle latency.
- **Random soak**: random valid/ready traffic, 10k beats, random cfg per beat, checked against a golden model -> zero mismatches.

Source files
------------

// File: rtl/gelu_requant_q35_if.sv
// Stream and control bundle for the accumulator-to-Q3.5 requantiser.
// The master side is the feeder/consumer pair and the slave side is the requantiser.
interface gelu_requant_q35_if #(
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned MULT_W  = 16,
  parameter int unsigned SHIFT_W = 5,
  parameter int unsigned CNT_W   = 16
);
  logic [MULT_W-1:0]  cfg_mult;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               in_valid;
  logic               in_ready;
  logic [ACC_W-1:0]   acc_in;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         y_q35;
  logic               sat_flag;
  logic [CNT_W-1:0]   sat_count;
  logic               sat_clr;

  modport master (
    output cfg_mult, cfg_shift, in_valid, acc_in, out_ready, sat_clr,
    input  in_ready, out_valid, y_q35, sat_flag, sat_count
  );

  modport slave (
    input  cfg_mult, cfg_shift, in_valid, acc_in, out_ready, sat_clr,
    output in_ready, out_valid, y_q35, sat_flag, sat_count
  );
endinterface

// File: rtl/gelu_requant_q35.sv
// Requantises signed MAC accumulators to saturated Q3.5 codes for the GELU stage.
// Stage 1 multiplies, stage 2 rounds/shifts/clamps; both stages stall under backpressure.
module gelu_requant_q35 #(
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned MULT_W  = 16,
  parameter int unsigned SHIFT_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  gelu_requant_q35_if.slave     bus
);

  localparam int unsigned PROD_W = ACC_W + MULT_W + 1;
  localparam int unsigned EXT_W  = PROD_W + 1;
  localparam logic signed [EXT_W-1:0] Y_MAX = {{(EXT_W-8){1'b0}}, 8'h7f};
  localparam logic signed [EXT_W-1:0] Y_MIN = {{(EXT_W-8){1'b1}}, 8'h80};

  logic                      w_s1_adv;
  logic                      w_s2_adv;
  logic                      w_in_fire;
  logic                      w_out_fire;
  logic signed [PROD_W-1:0]  w_acc_ext;
  logic signed [PROD_W-1:0]  w_mult_ext;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [EXT_W-1:0]   w_rnd;
  logic signed [EXT_W-1:0]   w_sum;
  logic signed [EXT_W-1:0]   w_shr;
  logic [7:0]                w_y;
  logic                      w_sat;

  logic                      r_s1_valid;
  logic signed [PROD_W-1:0]  r_s1_prod;
  logic [SHIFT_W-1:0]        r_s1_shift;
  logic                      r_s2_valid;
  logic [7:0]                r_y;
  logic                      r_sat;
  logic [CNT_W-1:0]          r_sat_count;

  // Handshake: a stage may load when it is empty or its successor is moving.
  always_comb begin
    w_s2_adv   = !r_s2_valid || bus.out_ready;
    w_s1_adv   = !r_s1_valid || w_s2_adv;
    w_in_fire  = bus.in_valid && w_s1_adv;
    w_out_fire = r_s2_valid && bus.out_ready;
  end

  // Multiplier is zero-extended so the product is a plain signed multiply.
  always_comb begin
    w_acc_ext  = PROD_W'($signed(bus.acc_in));
    w_mult_ext = PROD_W'($signed({1'b0, bus.cfg_mult}));
    w_prod     = w_acc_ext * w_mult_ext;
  end

  // Round half up with one guard bit, arithmetic shift, then clamp to int8.
  always_comb begin
    w_rnd = '0;
    if (r_s1_shift != '0) begin
      w_rnd = EXT_W'(1) << (r_s1_shift - SHIFT_W'(1));
    end
    w_sum = {r_s1_prod[PROD_W-1], r_s1_prod} + w_rnd;
    w_shr = w_sum >>> r_s1_shift;
    w_y   = w_shr[7:0];
    w_sat = 1'b0;
    if (w_shr > Y_MAX) begin
      w_y   = 8'h7f;
      w_sat = 1'b1;
    end else if (w_shr < Y_MIN) begin
      w_y   = 8'h80;
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_prod   <= '0;
      r_s1_shift  <= '0;
      r_s2_valid  <= 1'b0;
      r_y         <= '0;
      r_sat       <= 1'b0;
      r_sat_count <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= bus.in_valid;
        if (w_in_fire) begin
          r_s1_prod  <= w_prod;
          r_s1_shift <= bus.cfg_shift;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_y   <= w_y;
          r_sat <= w_sat;
        end
      end
      // Clear wins over a same-edge increment; the count sticks at all-ones.
      if (bus.sat_clr) begin
        r_sat_count <= '0;
      end else if (w_out_fire && r_sat && (r_sat_count != '1)) begin
        r_sat_count <= r_sat_count + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_s2_valid;
  assign bus.y_q35     = r_y;
  assign bus.sat_flag  = r_sat;
  assign bus.sat_count = r_sat_count;

endmodule

// File: tb/tb_gelu_requant_q35.sv
// Bench for gelu_requant_q35: directed vectors plus random soak against a queue model.
module tb_gelu_requant_q35;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gelu_requant_q35_if bus ();

  gelu_requant_q35 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int y;
    bit sat;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  int   got_y[$];
  int   cnt_model = 0;
  bit   prev_stall = 0;
  int   prev_y = 0;
  bit   prev_sat = 0;
  int   sent = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Requantisation written straight from the arithmetic definition.
  function automatic exp_t model(input longint acc, input longint mult, input int sh);
    longint p;
    longint r;
    exp_t   e;
    p = acc * mult;
    if (sh == 0) r = p;
    else         r = (p + (longint'(1) << (sh - 1))) >>> sh;
    if (r > 127) begin
      e.y = 127;   e.sat = 1'b1;
    end else if (r < -128) begin
      e.y = -128;  e.sat = 1'b1;
    end else begin
      e.y = int'(r); e.sat = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: sampled mid-cycle, so the values seen are those the next edge will act on.
  always @(negedge clk) begin
    exp_t e;
    int   y_act;
    if (reset) begin
      q.delete();
      cnt_model  = 0;
      prev_stall = 0;
    end else begin
      y_act = int'($signed(bus.y_q35));
      chk("sat_count", longint'(bus.sat_count), cnt_model);
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_y", y_act, prev_y);
        chk("hold_sat", bus.sat_flag, prev_sat);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("out_has_pending_beat", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("y_vs_model", y_act, e.y);
          chk("sat_vs_model", bus.sat_flag, e.sat);
          got_y.push_back(y_act);
          if (e.sat && cnt_model != 65535) cnt_model++;
        end
      end
      if (bus.sat_clr) cnt_model = 0;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(longint'($signed(bus.acc_in)), longint'(bus.cfg_mult),
                          int'(bus.cfg_shift)));
        sent++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_y     = y_act;
      prev_sat   = bus.sat_flag;
    end
  end

  // One beat with out_ready high: accepted, invisible one cycle later, visible the next.
  task automatic send_check(input string name, input longint acc, input longint mult,
                            input int sh, input int ey, input bit es);
    int waitc;
    waitc = 0;
    bus.acc_in    = 24'(acc);
    bus.cfg_mult  = 16'(mult);
    bus.cfg_shift = 5'(sh);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk({name, "_accept"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat1_valid"}, bus.out_valid, 0);
    @(negedge clk);
    chk({name, "_lat2_valid"}, bus.out_valid, 1);
    chk({name, "_y"}, $signed(bus.y_q35), ey);
    chk({name, "_sat"}, bus.sat_flag, es);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int   idx;
    int   start;
    int   mode;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.acc_in    = '0;
    bus.cfg_mult  = '0;
    bus.cfg_shift = '0;
    bus.out_ready = 1'b1;
    bus.sat_clr   = 1'b0;

    // Pin the model itself to hand-worked values.
    e = model(100, 32768, 16);     chk("model_nominal", e.y, 50);
    e = model(-3, 1, 1);           chk("model_tie_neg", e.y, -1);
    e = model(5, 1, 1);            chk("model_tie_pos", e.y, 3);
    e = model(-100000, 1, 0);      chk("model_sat_neg_y", e.y, -128);
                                   chk("model_sat_neg_f", e.sat, 1);
    e = model(1000, 65535, 31);    chk("model_big_shift", e.y, 0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_y", bus.y_q35, 0);
    chk("rst_sat_flag", bus.sat_flag, 0);
    chk("rst_sat_count", bus.sat_count, 0);
    @(posedge clk); #1;

    send_check("nominal", 100, 32768, 16, 50, 0);
    send_check("rnd_p3", 3, 1, 1, 2, 0);
    send_check("rnd_m3", -3, 1, 1, -1, 0);
    send_check("rnd_p5", 5, 1, 1, 3, 0);
    send_check("sh0_m7", -7, 1, 0, -7, 0);
    send_check("sat_neg", -100000, 1, 0, -128, 1);
    send_check("sat_pos", 200, 1, 0, 127, 1);
    send_check("edge_p127", 127, 1, 0, 127, 0);
    send_check("edge_m128", -128, 1, 0, -128, 0);
    @(negedge clk);
    chk("sat_count_two", bus.sat_count, 2);
    @(posedge clk); #1;
    bus.sat_clr = 1'b1;
    @(posedge clk); #1;
    bus.sat_clr = 1'b0;
    @(negedge clk);
    chk("sat_count_cleared", bus.sat_count, 0);
    @(posedge clk); #1;

    // Backpressure: only two beats fit while the consumer stalls.
    got_y.delete();
    bus.out_ready = 1'b0;
    bus.cfg_mult  = 16'd1;
    bus.cfg_shift = 5'd0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (idx < 4);
      bus.acc_in   = 24'(idx + 1);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_head_valid", bus.out_valid, 1);
    chk("bp_head_y", $signed(bus.y_q35), 1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30 && got_y.size() < 4; c++) begin
      bus.in_valid = (idx < 4);
      bus.acc_in   = 24'(idx + 1);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("bp_out_count", got_y.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_order", (i < got_y.size()) ? got_y[i] : -999, i + 1);
    end

    // Reset with two beats buffered; they must vanish.
    send_check("pre_rst_sat", 300, 1, 0, 127, 1);
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10 && idx < 2; c++) begin
      bus.in_valid = 1'b1;
      bus.acc_in   = 24'(20 + idx);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("rst_buffered", idx, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_sat_count", bus.sat_count, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    got_y.delete();
    send_check("post_rst", 9, 1, 0, 9, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_only_one", got_y.size(), 1);

    // Random soak with per-beat configuration.
    start = sent;
    for (int c = 0; c < 60000 && (sent - start) < 10000; c++) begin
      mode          = int'($urandom_range(2));
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      bus.sat_clr   = ($urandom_range(63) == 0);
      if (mode == 0) begin
        bus.acc_in    = 24'(int'($urandom_range(600)) - 300);
        bus.cfg_mult  = 16'($urandom_range(4));
        bus.cfg_shift = 5'($urandom_range(3));
      end else if (mode == 1) begin
        bus.acc_in    = 24'($urandom);
        bus.cfg_mult  = 16'($urandom);
        bus.cfg_shift = 5'($urandom);
      end else begin
        bus.acc_in    = 24'($urandom);
        bus.cfg_mult  = 16'($urandom);
        bus.cfg_shift = 5'($urandom_range(31, 20));
      end
      @(posedge clk); #1;
    end
    chk("soak_beats", sent - start, 10000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.sat_clr   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
    chk("drain_out_valid", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
